mul_norm_pipe: RTL and testbench

MUL_NORM_PIPE -- requirements
Module: mul_norm_pipe

---
 rtl/mul_norm_pipe.sv | 174 +++++++++++++++++
 tb/tb_mul_norm_pipe.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_norm_pipe.sv
// Normalizes a significand product and exponent into {sig, guard, sticky} plus flags; 2-cycle latency, 1 beat/cycle.
// Two valid/ready register stages; a stalled output holds stable and I_READY drops only when both stages are full.
module mul_norm_pipe #(
   parameter int MW = 24,
   parameter int EW = 10
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     I_VALID,
   output logic                     I_READY,
   input  logic [2*MW-1:0]          I_P,
   input  logic [EW-1:0]            I_EZ,
   output logic                     O_VALID,
   input  logic                     O_READY,
   output logic [MW+1:0]            O_SIG,
   output logic [EW-1:0]            O_EXP,
   output logic [$clog2(2*MW)-1:0]  O_SHL,
   output logic                     O_OVF,
   output logic                     O_DENORM,
   output logic                     O_ZERO
);
   localparam int PW = 2 * MW;
   localparam int SW = $clog2(PW);
   localparam int XW = EW + 2;
   localparam int GW = MW + 2;
   localparam logic signed [XW-1:0] ONE_X = XW'(1);
   localparam logic signed [XW-1:0] DMAX  = XW'(GW);
   localparam logic [GW-1:0]        ONES  = '1;

   logic            s1_vld_q, s1_vld_d;
   logic [PW-1:0]   s1_p_q, s1_p_d;
   logic [EW-1:0]   s1_e_q, s1_e_d;
   logic            s2_vld_q, s2_vld_d;
   logic [GW-1:0]   s2_sig_q, s2_sig_d;
   logic [EW-1:0]   s2_exp_q, s2_exp_d;
   logic [SW-1:0]   s2_shl_q, s2_shl_d;
   logic            s2_ovf_q, s2_ovf_d;
   logic            s2_den_q, s2_den_d;
   logic            s2_zero_q, s2_zero_d;
   logic            s1_ld, s2_ld;

   logic signed [XW-1:0] e_x, em1, lz_x, s_x, d_raw, d_sat;
   logic [SW-1:0]   lz, shl;
   logic            is_zero, top, e_neg, e_pos;
   logic [PW-2:0]   q;
   logic [GW-1:0]   sig_ovf, sig_s0, sig_nrm, sig_sub, sub_base, sub_shr, sub_lost;
   logic [EW-1:0]   exp_ovf, exp_nrm;
   logic [GW-1:0]   r_sig;
   logic [EW-1:0]   r_exp;
   logic [SW-1:0]   r_shl;
   logic            r_ovf, r_den, r_zero;

   // Stage-2 datapath: classify the beat held in S1 and align it.
   always_comb begin
      e_x = {{2{s1_e_q[EW-1]}}, s1_e_q};
      lz  = '0;
      for (int i = 0; i < PW - 1; i++) begin
         if (s1_p_q[i]) lz = SW'(PW - 2 - i);
      end
      is_zero = ~|s1_p_q;
      top     = s1_p_q[PW-1];
      e_neg   = e_x[XW-1];
      e_pos   = !e_neg && (|e_x);

      lz_x = {{(XW-SW){1'b0}}, lz};
      em1  = e_x - ONE_X;
      s_x  = (lz_x < em1) ? lz_x : em1;
      shl  = s_x[SW-1:0];
      q    = s1_p_q[PW-2:0] << shl;

      sig_ovf = {s1_p_q[PW-1 -: MW], s1_p_q[PW-MW-1], |s1_p_q[PW-MW-2:0]};
      sig_s0  = {s1_p_q[PW-2 -: MW], s1_p_q[PW-MW-2], |s1_p_q[PW-MW-3:0]};
      sig_nrm = {q[PW-2 -: MW], q[PW-MW-2], |q[PW-MW-3:0]};

      // Right shift saturates at the full field width so every bit lands in sticky.
      d_raw    = top ? -e_x : (ONE_X - e_x);
      d_sat    = (d_raw > DMAX) ? DMAX : d_raw;
      sub_base = top ? sig_ovf : sig_s0;
      sub_shr  = sub_base >> d_sat;
      sub_lost = sub_base & ~(ONES << d_sat);
      sig_sub  = {sub_shr[GW-1:1], sub_shr[0] | (|sub_lost)};

      exp_ovf = s1_e_q + EW'(1);
      exp_nrm = s1_e_q - s_x[EW-1:0];

      r_sig  = '0;
      r_exp  = '0;
      r_shl  = '0;
      r_ovf  = 1'b0;
      r_den  = 1'b0;
      r_zero = 1'b0;
      if (is_zero) begin
         r_zero = 1'b1;
      end else if (top && !e_neg) begin
         r_sig = sig_ovf;
         r_exp = exp_ovf;
         r_ovf = 1'b1;
      end else if (!top && e_pos) begin
         r_sig = sig_nrm;
         r_shl = shl;
         if (s_x == lz_x) r_exp = exp_nrm;
         else             r_den = 1'b1;
      end else begin
         r_sig = sig_sub;
         r_den = 1'b1;
         r_ovf = top;
      end
   end

   always_comb begin
      s2_ld   = !s2_vld_q || O_READY;
      s1_ld   = !s1_vld_q || s2_ld;
      I_READY = s1_ld;

      s1_vld_d = s1_ld ? I_VALID : s1_vld_q;
      s1_p_d   = s1_p_q;
      s1_e_d   = s1_e_q;
      if (s1_ld && I_VALID) begin
         s1_p_d = I_P;
         s1_e_d = I_EZ;
      end

      s2_vld_d  = s2_ld ? s1_vld_q : s2_vld_q;
      s2_sig_d  = s2_sig_q;
      s2_exp_d  = s2_exp_q;
      s2_shl_d  = s2_shl_q;
      s2_ovf_d  = s2_ovf_q;
      s2_den_d  = s2_den_q;
      s2_zero_d = s2_zero_q;
      if (s2_ld && s1_vld_q) begin
         s2_sig_d  = r_sig;
         s2_exp_d  = r_exp;
         s2_shl_d  = r_shl;
         s2_ovf_d  = r_ovf;
         s2_den_d  = r_den;
         s2_zero_d = r_zero;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         s1_vld_q  <= 1'b0;
         s1_p_q    <= '0;
         s1_e_q    <= '0;
         s2_vld_q  <= 1'b0;
         s2_sig_q  <= '0;
         s2_exp_q  <= '0;
         s2_shl_q  <= '0;
         s2_ovf_q  <= 1'b0;
         s2_den_q  <= 1'b0;
         s2_zero_q <= 1'b0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_p_q    <= s1_p_d;
         s1_e_q    <= s1_e_d;
         s2_vld_q  <= s2_vld_d;
         s2_sig_q  <= s2_sig_d;
         s2_exp_q  <= s2_exp_d;
         s2_shl_q  <= s2_shl_d;
         s2_ovf_q  <= s2_ovf_d;
         s2_den_q  <= s2_den_d;
         s2_zero_q <= s2_zero_d;
      end
   end

   assign O_VALID  = s2_vld_q;
   assign O_SIG    = s2_sig_q;
   assign O_EXP    = s2_exp_q;
   assign O_SHL    = s2_shl_q;
   assign O_OVF    = s2_ovf_q;
   assign O_DENORM = s2_den_q;
   assign O_ZERO   = s2_zero_q;

endmodule

// File: tb/tb_mul_norm_pipe.sv
// Scoreboard bench for mul_norm_pipe: directed corner beats, random beats against an arithmetic model,
// backpressure stalls and a mid-stream reset.
module tb_mul_norm_pipe;
   logic        CLK, RST, I_VALID, I_READY, O_VALID, O_READY, O_OVF, O_DENORM, O_ZERO;
   logic [47:0] I_P;
   logic [9:0]  I_EZ, O_EXP;
   logic [25:0] O_SIG;
   logic [5:0]  O_SHL;
   logic [45:0] out_bus;

   typedef struct packed {
      logic [25:0] sig;
      logic [9:0]  exp;
      logic [5:0]  shl;
      logic        ovf;
      logic        den;
      logic        zero;
   } res_t;

   typedef struct {
      res_t r;
      int   cyc;
      bit   lat;
   } sb_t;

   sb_t sb[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   bit  rdy_mode = 0;
   bit  rdy_force = 1;

   mul_norm_pipe #(.MW(24), .EW(10)) dut (
      .CLK(CLK), .RST(RST),
      .I_VALID(I_VALID), .I_READY(I_READY), .I_P(I_P), .I_EZ(I_EZ),
      .O_VALID(O_VALID), .O_READY(O_READY), .O_SIG(O_SIG), .O_EXP(O_EXP),
      .O_SHL(O_SHL), .O_OVF(O_OVF), .O_DENORM(O_DENORM), .O_ZERO(O_ZERO)
   );

   assign out_bus = {O_VALID, O_SIG, O_EXP, O_SHL, O_OVF, O_DENORM, O_ZERO};

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   initial begin
      O_READY = 1'b1;
      forever begin
         @(posedge CLK);
         #1;
         O_READY = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_force;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached (checks %0d, errors %0d)", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Take 24 bits starting at bit msb, then the guard bit, then OR of everything below.
   function automatic logic [25:0] pack(logic [63:0] v, int msb);
      logic [63:0] hi, g, rem;
      hi  = (v >> (msb - 23)) & 64'hFF_FFFF;
      g   = (v >> (msb - 24)) & 64'd1;
      rem = v & ((64'd1 << (msb - 24)) - 64'd1);
      return {hi[23:0], g[0], rem != 64'd0};
   endfunction

   function automatic res_t model(logic [47:0] p, int e);
      res_t r;
      int msb, l, s, d;
      logic [63:0] base, ex, lost;
      r = '0;
      if (p == 48'd0) begin
         r.zero = 1'b1;
      end else if (p[47] && e >= 0) begin
         r.sig = pack(64'(p), 47);
         r.exp = 10'(e + 1);
         r.ovf = 1'b1;
      end else if (!p[47] && e >= 1) begin
         msb = 0;
         for (int i = 0; i < 47; i++) if (p[i]) msb = i;
         l = 46 - msb;
         s = (l < e - 1) ? l : e - 1;
         r.sig = pack(64'(p) << s, 46);
         r.shl = 6'(s);
         if (s == l) r.exp = 10'(e - s);
         else        r.den = 1'b1;
      end else begin
         base = 64'(pack(64'(p), p[47] ? 47 : 46));
         d = p[47] ? -e : 1 - e;
         if (d > 26) d = 26;
         ex   = base >> d;
         lost = base - (ex << d);
         r.sig = {ex[25:1], ex[0] | (lost != 64'd0)};
         r.den = 1'b1;
         r.ovf = p[47];
      end
      return r;
   endfunction

   function automatic res_t mk(logic [23:0] m, logic g, logic s, int e, int sh,
                               logic ovf, logic den, logic zero);
      res_t r;
      r.sig  = {m, g, s};
      r.exp  = 10'(e);
      r.shl  = 6'(sh);
      r.ovf  = ovf;
      r.den  = den;
      r.zero = zero;
      return r;
   endfunction

   // Called 2 time units after a rising edge; returns at the same phase after the transfer.
   task automatic send(logic [47:0] p, int e, res_t exp, bit lat);
      sb_t it;
      bit  done;
      int  n;
      done = 0;
      n = 0;
      I_VALID = 1'b1;
      I_P = p;
      I_EZ = 10'(e);
      while (!done && n < 200) begin
         @(negedge CLK);
         if (I_READY) begin
            it.r = exp;
            it.cyc = cyc;
            it.lat = lat;
            sb.push_back(it);
            done = 1;
         end
         @(posedge CLK);
         #2;
         n++;
      end
      check("accept", 64'(done), 64'd1);
      I_VALID = 1'b0;
   endtask

   task automatic gen(output logic [47:0] p, output int e);
      logic [63:0] r;
      r = {$urandom, $urandom};
      p = r[47:0];
      case ($urandom_range(0, 7))
         0: p = '0;
         1: p[47] = 1'b1;
         2, 3, 4, 5: p = p >> $urandom_range(1, 47);
         6: p = 48'd1 << $urandom_range(0, 46);
         default: ;
      endcase
      case ($urandom_range(0, 3))
         0: e = int'($urandom_range(0, 60)) - 30;
         1: e = int'($urandom_range(0, 1023)) - 512;
         2: e = int'($urandom_range(0, 6)) - 3;
         default: e = int'($urandom_range(0, 100)) - 60;
      endcase
   endtask

   task automatic send_rand(bit lat);
      logic [47:0] p;
      int e;
      gen(p, e);
      send(p, e, model(p, e), lat);
   endtask

   task automatic drain();
      for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge CLK);
      check("drain_empty", 64'(sb.size()), 64'd0);
      @(posedge CLK);
      #2;
   endtask

   // Monitor: pops on every output transfer and checks stalled outputs hold.
   initial begin
      sb_t it;
      logic [45:0] held;
      bit hold;
      hold = 0;
      held = '0;
      forever begin
         @(negedge CLK);
         if (!RST) begin
            hold = 0;
         end else begin
            if (hold) check("hold_stable", 64'(out_bus), 64'(held));
            if (O_VALID && O_READY) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output: sig %0h exp %0h with no beat pending", O_SIG, O_EXP);
               end else begin
                  it = sb.pop_front();
                  check("sig", 64'(O_SIG), 64'(it.r.sig));
                  check("exp", 64'(O_EXP), 64'(it.r.exp));
                  check("shl", 64'(O_SHL), 64'(it.r.shl));
                  check("flags", 64'({O_OVF, O_DENORM, O_ZERO}), 64'({it.r.ovf, it.r.den, it.r.zero}));
                  if (it.lat) check("latency", 64'(cyc - it.cyc), 64'd2);
               end
            end
            hold = O_VALID && !O_READY;
            held = out_bus;
         end
      end
   end

   initial begin
      RST = 1'b0;
      I_VALID = 1'b0;
      I_P = '0;
      I_EZ = '0;
      #3;
      check("rst_outputs", 64'(out_bus), 64'd0);
      check("rst_i_ready", 64'(I_READY), 64'd1);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      #2;

      send(48'h8000_0000_0000, 100, mk(24'h800000, 0, 0, 101, 0, 1, 0, 0), 1);
      send(48'h4000_0000_0001, 5,   mk(24'h800000, 0, 1, 5, 0, 0, 0, 0), 1);
      send(48'd1 << 36, 4,          mk(24'h010000, 0, 0, 0, 3, 0, 1, 0), 1);
      send(48'd0, 50,               mk(24'h000000, 0, 0, 0, 0, 0, 0, 1), 1);
      send(48'd1 << 46, -2,         mk(24'h100000, 0, 0, 0, 0, 0, 1, 0), 1);
      send(48'd1 << 46, -40,        mk(24'h000000, 0, 1, 0, 0, 0, 1, 0), 1);
      send(48'hC000_0000_0000, -1,  mk(24'h600000, 0, 0, 0, 0, 1, 1, 0), 1);
      send(48'd1 << 46, 0,          mk(24'h400000, 0, 0, 0, 0, 0, 1, 0), 1);
      send(48'd1 << 44, 3,          mk(24'h800000, 0, 0, 1, 2, 0, 0, 0), 1);
      send((48'd1 << 46) | 48'd1, -1, mk(24'h200000, 0, 1, 0, 0, 0, 1, 0), 1);

      for (int k = 0; k < 100; k++) begin
         send_rand(1);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge CLK);
            #2;
         end
      end
      drain();

      rdy_force = 0;
      @(posedge CLK);
      #2;
      fork
         begin
            for (int k = 0; k < 4; k++) send_rand(0);
         end
         begin
            repeat (3) @(negedge CLK);
            check("bp_i_ready_low", 64'(I_READY), 64'd0);
            check("bp_o_valid", 64'(O_VALID), 64'd1);
            @(negedge CLK);
            rdy_force = 1;
         end
      join
      drain();

      rdy_mode = 1;
      for (int k = 0; k < 400; k++) begin
         send_rand(0);
         if ($urandom_range(0, 4) == 0) begin
            @(posedge CLK);
            #2;
         end
      end
      rdy_mode = 0;
      rdy_force = 1;
      drain();

      rdy_force = 0;
      @(posedge CLK);
      #2;
      send(48'h8000_0000_0000, 7, mk(24'h800000, 0, 0, 8, 0, 1, 0, 0), 0);
      send(48'h4000_0000_0000, 9, mk(24'h800000, 0, 0, 9, 0, 0, 0, 0), 0);
      check("pre_rst_full", 64'({O_VALID, I_READY}), 64'b10);
      #2;
      RST = 1'b0;
      #1;
      check("midrst_outputs", 64'(out_bus), 64'd0);
      check("midrst_i_ready", 64'(I_READY), 64'd1);
      sb.delete();
      @(negedge CLK);
      RST = 1'b1;
      rdy_force = 1;
      @(posedge CLK);
      #2;
      send(48'd1 << 46, 5, mk(24'h800000, 0, 0, 5, 0, 0, 0, 0), 1);
      drain();
      repeat (3) @(posedge CLK);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
